// File: rtl/piso_shift_register.sv
// piso_shift_register
// Parallel-in/serial-out shifter. One word is accepted on the valid/ready load port.
// It is then streamed out one bit per accepted serial beat.
// serial_out is always taken straight from a register bit.

module piso_shift_register #(
  parameter int width     = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [width-1:0]         parallelIn,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic                     serial_out,
  output logic                     serial_valid,
  input  logic                     serial_ready,
  output logic                     last,
  output logic                     busy,
  output logic [$clog2(width):0]   bits_left
);

  localparam int CW = $clog2(width) + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [width-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [width-1:0] shreg_shifted;
  logic             beat;

  // Shift one position toward the output end and fill the vacated bit with 0.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shreg_shifted = {shreg_q[width-2:0], 1'b0};
      assign serial_out    = shreg_q[width-1];
    end else begin : g_lsb_first
      assign shreg_shifted = {1'b0, shreg_q[width-1:1]};
      assign serial_out    = shreg_q[0];
    end
  endgenerate

  assign beat         = (state_q == ST_SHIFT) && serial_ready;
  assign load_ready   = (state_q == ST_IDLE);
  assign serial_valid = (state_q == ST_SHIFT);
  assign busy         = (state_q == ST_SHIFT);
  assign last         = (state_q == ST_SHIFT) && (cnt_q == CW'(1));
  assign bits_left    = cnt_q;

  // Next-state logic. clear overrides both a load and a serial beat.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = ST_IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_valid) begin
            shreg_d = parallelIn;
            cnt_d   = CW'(width);
            state_d = ST_SHIFT;
          end
        end
        default: begin
          // A new load is ignored while shifting. The held word only advances on a beat.
          if (beat) begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_d = ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  // State, shift register and bit counter. The asynchronous reset returns all of them to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_shift_register.sv
// tb_piso_shift_register
// Directed bench: an LSB-first width-8 instance plus an MSB-first width-8 instance.

module tb_piso_shift_register;

  logic       clk = 1'b0;
  logic       rst_n;

  // LSB-first instance
  logic       clear, ld_valid, s_ready;
  logic [7:0] par_in;
  logic       ld_ready, s_out, s_valid, last, busy;
  logic [3:0] bits_left;

  // MSB-first instance
  logic       clear2, ld_valid2, s_ready2;
  logic [7:0] par_in2;
  logic       ld_ready2, s_out2, s_valid2, last2, busy2;
  logic [3:0] bits_left2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_shift_register #(.width(8), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .parallelIn(par_in),
    .load_valid(ld_valid), .load_ready(ld_ready), .serial_out(s_out),
    .serial_valid(s_valid), .serial_ready(s_ready), .last(last),
    .busy(busy), .bits_left(bits_left)
  );

  piso_shift_register #(.width(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .clear(clear2), .parallelIn(par_in2),
    .load_valid(ld_valid2), .load_ready(ld_ready2), .serial_out(s_out2),
    .serial_valid(s_valid2), .serial_ready(s_ready2), .last(last2),
    .busy(busy2), .bits_left(bits_left2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".load_ready"}, {31'd0, ld_ready}, 32'd1);
    chk({tag, ".serial_valid"}, {31'd0, s_valid}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".bits_left"}, {28'd0, bits_left}, 32'd0);
    chk({tag, ".last"}, {31'd0, last}, 32'd0);
  endtask

  logic [7:0] exp_word;

  initial begin
    rst_n = 1'b0;
    clear = 1'b0; ld_valid = 1'b0; s_ready = 1'b0; par_in = 8'h00;
    clear2 = 1'b0; ld_valid2 = 1'b0; s_ready2 = 1'b0; par_in2 = 8'h00;
    #2;
    // Reset values
    chk_idle("reset");
    chk("reset.serial_out", {31'd0, s_out}, 32'd0);
    chk("reset_msb.load_ready", {31'd0, ld_ready2}, 32'd1);
    chk("reset_msb.serial_out", {31'd0, s_out2}, 32'd0);
    adv();
    rst_n = 1'b1;
    adv();

    // Load A5 with serial_ready held high
    exp_word = 8'hA5;
    par_in = 8'hA5; ld_valid = 1'b1; s_ready = 1'b1;
    adv();
    ld_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      $display("t=%0t A5 bit %0d serial_out=%0b last=%0b bits_left=%0d", $time, i, s_out, last, bits_left);
      chk($sformatf("a5.bit%0d", i), {31'd0, s_out}, {31'd0, exp_word[i]});
      chk($sformatf("a5.last%0d", i), {31'd0, last}, (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("a5.bits_left%0d", i), {28'd0, bits_left}, 32'(8 - i));
      chk($sformatf("a5.load_ready%0d", i), {31'd0, ld_ready}, 32'd0);
      chk($sformatf("a5.valid%0d", i), {31'd0, s_valid}, 32'd1);
      adv();
    end
    chk_idle("a5.done");

    // Load 3C with serial_ready toggling; each bit stalls one cycle before its beat
    exp_word = 8'h3C;
    par_in = 8'h3C; ld_valid = 1'b1;
    adv();
    ld_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_ready = 1'b0;
      chk($sformatf("3c.bit%0d", i), {31'd0, s_out}, {31'd0, exp_word[i]});
      adv();
      $display("t=%0t 3C stall bit %0d serial_out=%0b bits_left=%0d", $time, i, s_out, bits_left);
      chk($sformatf("3c.stall_bit%0d", i), {31'd0, s_out}, {31'd0, exp_word[i]});
      chk($sformatf("3c.stall_left%0d", i), {28'd0, bits_left}, 32'(8 - i));
      chk($sformatf("3c.stall_last%0d", i), {31'd0, last}, (i == 7) ? 32'd1 : 32'd0);
      s_ready = 1'b1;
      adv();
    end
    chk_idle("3c.done");

    // Load 01 while load_valid stays high with FF
    exp_word = 8'h01;
    par_in = 8'h01; ld_valid = 1'b1;
    adv();
    par_in = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      $display("t=%0t 01 bit %0d serial_out=%0b load_ready=%0b", $time, i, s_out, ld_ready);
      chk($sformatf("01.bit%0d", i), {31'd0, s_out}, {31'd0, exp_word[i]});
      chk($sformatf("01.load_ready%0d", i), {31'd0, ld_ready}, 32'd0);
      if (i == 7) ld_valid = 1'b0;
      adv();
    end
    chk_idle("01.done");

    // Clear at bits_left=5 with a simultaneous load
    par_in = 8'hAA; ld_valid = 1'b1;
    adv();
    ld_valid = 1'b0;
    adv(); adv(); adv();
    chk("clr.bits_left_before", {28'd0, bits_left}, 32'd5);
    clear = 1'b1; ld_valid = 1'b1; par_in = 8'hFF;
    adv();
    clear = 1'b0; ld_valid = 1'b0;
    $display("t=%0t clear busy=%0b bits_left=%0d serial_out=%0b", $time, busy, bits_left, s_out);
    chk_idle("clr.after");
    chk("clr.serial_out", {31'd0, s_out}, 32'd0);
    adv();
    chk_idle("clr.later");

    // MSB-first instance: load C0
    exp_word = 8'hC0;
    par_in2 = 8'hC0; ld_valid2 = 1'b1; s_ready2 = 1'b1;
    adv();
    ld_valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      $display("t=%0t C0 msb bit %0d serial_out=%0b last=%0b", $time, i, s_out2, last2);
      chk($sformatf("c0.bit%0d", i), {31'd0, s_out2}, {31'd0, exp_word[7 - i]});
      chk($sformatf("c0.last%0d", i), {31'd0, last2}, (i == 7) ? 32'd1 : 32'd0);
      adv();
    end
    chk("c0.done_ready", {31'd0, ld_ready2}, 32'd1);
    chk("c0.done_busy", {31'd0, busy2}, 32'd0);

    // Asynchronous reset mid-transfer, with no clock edge
    par_in = 8'hFF; ld_valid = 1'b1;
    adv();
    ld_valid = 1'b0;
    adv(); adv();
    chk("arst.busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    $display("t=%0t async reset busy=%0b bits_left=%0d", $time, busy, bits_left);
    chk_idle("arst");
    chk("arst.serial_out", {31'd0, s_out}, 32'd0);
    adv();
    rst_n = 1'b1;
    adv();
    chk_idle("arst.released");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
